// File: rtl/ex_mem_pkg.sv
// Core-wide definitions shared by the pipeline registers: bus widths, NOP code,
// stall-vector bit positions and reset polarity.
package ex_mem_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned AddrWidth  = 5;
  localparam int unsigned AluOpWidth = 8;
  localparam int unsigned StallWidth = 6;

  // Stall vector: bit 0 = PC ... bit 5 = WB.
  localparam int unsigned ExStallIdx  = 3;
  localparam int unsigned MemStallIdx = 4;

  localparam logic [DataWidth-1:0]  ZeroWord  = '0;
  localparam logic [AluOpWidth-1:0] AluOpNop  = '0;
  localparam logic                  RstEnable = 1'b1;

endpackage

// File: rtl/ex_mem_if.sv
// Execute-to-memory pipeline bus: ex_* fields in, registered mem_* fields out,
// plus the multi-cycle intermediate state returned to execute.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWidth,
  parameter int unsigned ADDR_W  = AddrWidth,
  parameter int unsigned ALUOP_W = AluOpWidth
);

  logic                  ex_valid;
  logic [ADDR_W-1:0]     ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_whilo;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [DATA_W-1:0]     ex_mem_addr;
  logic [DATA_W-1:0]     ex_reg2;
  logic [2*DATA_W-1:0]   ex_hilo_tmp;
  logic [1:0]            ex_cnt;

  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic [ALUOP_W-1:0]    mem_aluop;
  logic [DATA_W-1:0]     mem_mem_addr;
  logic [DATA_W-1:0]     mem_reg2;
  logic [2*DATA_W-1:0]   hilo_tmp_o;
  logic [1:0]            cnt_o;

  // Execute side.
  modport master (
    output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
           ex_mem_addr, ex_reg2, ex_hilo_tmp, ex_cnt,
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_tmp_o, cnt_o
  );

  // Pipeline register side.
  modport slave (
    input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
           ex_mem_addr, ex_reg2, ex_hilo_tmp, ex_cnt,
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_tmp_o, cnt_o
  );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with hold / bubble / advance / flush control; also
// loops MADD/MSUB intermediate state back to execute while execute is stalled.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWidth,
  parameter int unsigned ADDR_W  = AddrWidth,
  parameter int unsigned ALUOP_W = AluOpWidth,
  parameter int unsigned STALL_W = StallWidth,
  parameter int unsigned EX_IDX  = ExStallIdx,
  parameter int unsigned MEM_IDX = MemStallIdx
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus
);

  localparam logic [DATA_W-1:0]  ZeroData = DATA_W'(ZeroWord);
  localparam logic [ADDR_W-1:0]  ZeroAddr = '0;
  localparam logic [ALUOP_W-1:0] NopCode  = ALUOP_W'(AluOpNop);

  // Only the EX and MEM bits steer this register.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      bus.mem_valid    <= 1'b0;
      bus.mem_wd       <= ZeroAddr;
      bus.mem_wreg     <= 1'b0;
      bus.mem_wdata    <= ZeroData;
      bus.mem_whilo    <= 1'b0;
      bus.mem_hi       <= ZeroData;
      bus.mem_lo       <= ZeroData;
      bus.mem_aluop    <= NopCode;
      bus.mem_mem_addr <= ZeroData;
      bus.mem_reg2     <= ZeroData;
      bus.hilo_tmp_o   <= '0;
      bus.cnt_o        <= 2'd0;
    end else if (stall[EX_IDX] && !stall[MEM_IDX]) begin
      // Bubble to MEM, but keep the execute stage's partial result alive.
      bus.mem_valid    <= 1'b0;
      bus.mem_wd       <= ZeroAddr;
      bus.mem_wreg     <= 1'b0;
      bus.mem_wdata    <= ZeroData;
      bus.mem_whilo    <= 1'b0;
      bus.mem_hi       <= ZeroData;
      bus.mem_lo       <= ZeroData;
      bus.mem_aluop    <= NopCode;
      bus.mem_mem_addr <= ZeroData;
      bus.mem_reg2     <= ZeroData;
      bus.hilo_tmp_o   <= bus.ex_hilo_tmp;
      bus.cnt_o        <= bus.ex_cnt;
    end else if (!stall[EX_IDX]) begin
      // EX running with MEM stalled is illegal upstream; it still advances.
      bus.mem_valid    <= bus.ex_valid;
      bus.mem_wd       <= bus.ex_wd;
      bus.mem_wreg     <= bus.ex_wreg;
      bus.mem_wdata    <= bus.ex_wdata;
      bus.mem_whilo    <= bus.ex_whilo;
      bus.mem_hi       <= bus.ex_hi;
      bus.mem_lo       <= bus.ex_lo;
      bus.mem_aluop    <= bus.ex_aluop;
      bus.mem_mem_addr <= bus.ex_mem_addr;
      bus.mem_reg2     <= bus.ex_reg2;
      bus.hilo_tmp_o   <= '0;
      bus.cnt_o        <= 2'd0;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Directed-vector bench for the EX/MEM pipeline register.
module tb_ex_mem;
  import ex_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  int         total = 0;
  int         bad = 0;

  ex_mem_if bus ();

  ex_mem dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                        input logic [31:0] lo, input logic [7:0] aluop,
                        input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [63:0] tmp, input logic [1:0] cnt);
    bus.ex_valid    = v;
    bus.ex_wd       = wd;
    bus.ex_wreg     = wreg;
    bus.ex_wdata    = wdata;
    bus.ex_whilo    = whilo;
    bus.ex_hi       = hi;
    bus.ex_lo       = lo;
    bus.ex_aluop    = aluop;
    bus.ex_mem_addr = addr;
    bus.ex_reg2     = reg2;
    bus.ex_hilo_tmp = tmp;
    bus.ex_cnt      = cnt;
  endtask

  // Snapshot of every registered output, 242 bits.
  function automatic logic [241:0] all_out();
    return {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
            bus.mem_hi, bus.mem_lo, bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2,
            bus.hilo_tmp_o, bus.cnt_o};
  endfunction

  task automatic test_reset();
    set_ex(1'b1, 5'h1F, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    stall = 6'b000000;
    flush = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (all_out() !== 242'd0) begin
        bad++;
        $display("FAIL reset_cycle%0d outputs got=%h want=0", i, all_out());
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.mem_wdata !== 32'hFFFF_FFFF || bus.mem_wd !== 5'h1F || bus.mem_valid !== 1'b1 ||
        bus.mem_aluop !== 8'hFF || bus.mem_lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL reset_release wdata=%h wd=%h valid=%b aluop=%h lo=%h want all ones",
               bus.mem_wdata, bus.mem_wd, bus.mem_valid, bus.mem_aluop, bus.mem_lo);
    end
    total++;
    if (bus.cnt_o !== 2'd0 || bus.hilo_tmp_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_release_tmp cnt=%0d tmp=%h want 0/0", bus.cnt_o, bus.hilo_tmp_o);
    end
  endtask

  task automatic test_advance();
    set_ex(1'b1, 5'd5, 1'b1, 32'h0000_00F0, 1'b0, 32'h0, 32'h0, 8'h21, 32'h0000_0100,
           32'h0000_0055, 64'h0, 2'd0);
    stall = 6'b000000;
    step();
    total++;
    if (bus.mem_wd !== 5'd5 || bus.mem_wreg !== 1'b1 || bus.mem_wdata !== 32'h0000_00F0 ||
        bus.cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL advance wd=%0d wreg=%b wdata=%h cnt=%0d want 5/1/000000f0/0",
               bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.cnt_o);
    end
    total++;
    if (bus.mem_aluop !== 8'h21 || bus.mem_mem_addr !== 32'h100 || bus.mem_reg2 !== 32'h55 ||
        bus.mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL advance_ls aluop=%h addr=%h reg2=%h valid=%b want 21/100/55/1",
               bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2, bus.mem_valid);
    end
  endtask

  task automatic test_bubble();
    set_ex(1'b1, 5'd7, 1'b1, 32'h1111_2222, 1'b1, 32'h3, 32'h4, 8'h1C, 32'h8, 32'h9,
           64'h1_0000_0002, 2'd1);
    stall = 6'b001111;
    step();
    total++;
    if (bus.mem_wreg !== 1'b0 || bus.mem_aluop !== 8'h00 || bus.mem_valid !== 1'b0 ||
        bus.mem_whilo !== 1'b0 || bus.mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL bubble_mem wreg=%b aluop=%h valid=%b whilo=%b wdata=%h want zeros",
               bus.mem_wreg, bus.mem_aluop, bus.mem_valid, bus.mem_whilo, bus.mem_wdata);
    end
    total++;
    if (bus.cnt_o !== 2'd1 || bus.hilo_tmp_o !== 64'h1_0000_0002) begin
      bad++;
      $display("FAIL bubble_tmp cnt=%0d tmp=%h want 1/0000000100000002",
               bus.cnt_o, bus.hilo_tmp_o);
    end
    // Stall held: each cycle is a fresh bubble re-capturing the intermediate state.
    for (int i = 0; i < 3; i++) begin
      bus.ex_hilo_tmp = 64'(i + 10);
      bus.ex_cnt      = 2'(i);
      step();
      total++;
      if (bus.mem_wreg !== 1'b0 || bus.hilo_tmp_o !== 64'(i + 10) ||
          bus.cnt_o !== 2'(i)) begin
        bad++;
        $display("FAIL bubble_k%0d wreg=%b tmp=%h cnt=%0d want 0/%h/%0d", i, bus.mem_wreg,
                 bus.hilo_tmp_o, bus.cnt_o, 64'(i + 10), i);
      end
    end
  endtask

  task automatic test_hold();
    set_ex(1'b1, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 8'h21, 32'h0, 32'h0,
           64'h0, 2'd0);
    stall = 6'b000000;
    step();
    set_ex(1'b1, 5'd2, 1'b1, 32'h0BAD_F00D, 1'b1, 32'h7, 32'h7, 8'h33, 32'h44, 32'h55,
           64'hABCD, 2'd3);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wd !== 5'd9 || bus.cnt_o !== 2'd0 ||
          bus.hilo_tmp_o !== 64'd0) begin
        bad++;
        $display("FAIL hold%0d wdata=%h wd=%0d cnt=%0d tmp=%h want deadbeef/9/0/0", i,
                 bus.mem_wdata, bus.mem_wd, bus.cnt_o, bus.hilo_tmp_o);
      end
    end
    // Hold also preserves a non-zero intermediate state.
    bus.ex_hilo_tmp = 64'hABC;
    bus.ex_cnt      = 2'd2;
    stall = 6'b001111;
    step();
    bus.ex_hilo_tmp = 64'h999;
    bus.ex_cnt      = 2'd1;
    stall = 6'b011111;
    step();
    step();
    total++;
    if (bus.cnt_o !== 2'd2 || bus.hilo_tmp_o !== 64'hABC) begin
      bad++;
      $display("FAIL hold_tmp cnt=%0d tmp=%h want 2/abc", bus.cnt_o, bus.hilo_tmp_o);
    end
  endtask

  task automatic test_flush();
    set_ex(1'b1, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'hA, 32'hB, 8'h21, 32'hC, 32'hD,
           64'h0, 2'd0);
    stall = 6'b000000;
    step();
    flush = 1'b1;
    stall = 6'b011111;
    step();
    total++;
    if (all_out() !== 242'd0) begin
      bad++;
      $display("FAIL flush_over_hold outputs got=%h want=0", all_out());
    end
    flush = 1'b0;
    stall = 6'b001111;
    bus.ex_hilo_tmp = 64'h55;
    bus.ex_cnt      = 2'd1;
    step();
    flush = 1'b1;
    step();
    total++;
    if (all_out() !== 242'd0) begin
      bad++;
      $display("FAIL flush_over_bubble outputs got=%h want=0", all_out());
    end
    flush = 1'b0;
  endtask

  task automatic test_multicycle();
    stall = 6'b001111;
    set_ex(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h1C, 32'h0, 32'h0,
           64'h0000_0003_0000_0004, 2'd1);
    step();
    total++;
    if (bus.cnt_o !== 2'd1 || bus.hilo_tmp_o !== 64'h0000_0003_0000_0004 ||
        bus.mem_whilo !== 1'b0 || bus.mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL madd_cycle1 cnt=%0d tmp=%h whilo=%b valid=%b want 1/300000004/0/0",
               bus.cnt_o, bus.hilo_tmp_o, bus.mem_whilo, bus.mem_valid);
    end
    stall = 6'b000000;
    set_ex(1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0003, 32'h0000_0008, 8'h1C, 32'h0, 32'h0,
           64'h0000_0003_0000_0004, 2'd2);
    step();
    total++;
    if (bus.mem_whilo !== 1'b1 || bus.mem_hi !== 32'h3 || bus.mem_lo !== 32'h8 ||
        bus.mem_aluop !== 8'h1C || bus.cnt_o !== 2'd0 || bus.hilo_tmp_o !== 64'd0) begin
      bad++;
      $display("FAIL madd_result whilo=%b hi=%h lo=%h aluop=%h cnt=%0d tmp=%h want 1/3/8/1c/0/0",
               bus.mem_whilo, bus.mem_hi, bus.mem_lo, bus.mem_aluop, bus.cnt_o, bus.hilo_tmp_o);
    end
    // Reset mid-operation clears the intermediate state the same edge.
    stall = 6'b001111;
    bus.ex_cnt = 2'd1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.cnt_o !== 2'd0 || bus.hilo_tmp_o !== 64'd0) begin
      bad++;
      $display("FAIL madd_reset cnt=%0d tmp=%h want 0/0", bus.cnt_o, bus.hilo_tmp_o);
    end
  endtask

  task automatic test_stall_decode();
    // EX running while MEM stalled: illegal from the controller, register advances.
    stall = 6'b010000;
    $display("protocol error: stall[EX]=0 with stall[MEM]=1 driven (controller illegal)");
    set_ex(1'b1, 5'd11, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 8'h21, 32'h0, 32'h0,
           64'h77, 2'd1);
    step();
    total++;
    if (bus.mem_wdata !== 32'h0000_1234 || bus.mem_wd !== 5'd11 || bus.cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL illegal_stall_adv wdata=%h wd=%0d cnt=%0d want 1234/11/0",
               bus.mem_wdata, bus.mem_wd, bus.cnt_o);
    end
    // Unrelated stall bits are ignored.
    stall = 6'b100111;
    bus.ex_wdata = 32'hCAFE_0001;
    step();
    total++;
    if (bus.mem_wdata !== 32'hCAFE_0001 || bus.mem_wreg !== 1'b1) begin
      bad++;
      $display("FAIL other_bits wdata=%h wreg=%b want cafe0001/1", bus.mem_wdata,
               bus.mem_wreg);
    end
    stall = 6'b101111;
    step();
    total++;
    if (bus.mem_wreg !== 1'b0 || bus.cnt_o !== 2'd1 || bus.hilo_tmp_o !== 64'h77) begin
      bad++;
      $display("FAIL other_bits_bubble wreg=%b cnt=%0d tmp=%h want 0/1/77", bus.mem_wreg,
               bus.cnt_o, bus.hilo_tmp_o);
    end
  endtask

  initial begin
    rst   = 1'b1;
    stall = 6'b000000;
    flush = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h0, 32'h0, 32'h0, 64'h0, 2'd0);
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_multicycle();
    test_stall_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the 5-stage integer core. Captures the execute stage's write-back, HI/LO and load/store fields on each clock edge and presents them to the memory stage. Implements the core's stall/flush protocol: hold, bubble insertion and full flush. Also carries the intermediate state of two-cycle execute operations (MADD/MSUB family) back to the execute stage while the execute stage is stalled.

## Interface
Parameters:
- DATA_W, 32, general register / HI / LO width
- ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU operation code width
- STALL_W, 6, stall vector width (bit 0 = PC … bit 5 = WB)
- EX_IDX, 3, stall-vector bit for execute
- MEM_IDX, 4, stall-vector bit for memory

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  per-stage stall request from stall controller
- flush  in  1  exception flush, kills the instruction in this register
- ex_valid  in  1  execute stage holds a real instruction
- ex_wd / ex_wreg / ex_wdata  in  ADDR_W / 1 / DATA_W  destination register, write enable, result
- ex_whilo / ex_hi / ex_lo  in  1 / DATA_W / DATA_W  HI/LO write enable and values
- ex_aluop  in  ALUOP_W  operation code (memory stage decodes loads/stores from it)
- ex_mem_addr / ex_reg2  in  DATA_W / DATA_W  effective address, store data
- ex_hilo_tmp / ex_cnt  in  2*DATA_W / 2  multi-cycle intermediate product and cycle count
- mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as the matching ex_ inputs  registered copies for the memory stage
- hilo_tmp_o / cnt_o  out  2*DATA_W / 2  intermediate state returned to execute

## Operation
- All outputs registered; updated only on rising clk. Evaluation priority per edge, first match wins:
  1. rst=1: every output ← 0 (mem_aluop = NOP code 0, mem_valid=0).
  2. flush=1: every output ← 0, including hilo_tmp_o and cnt_o. flush is not gated by stall.
  3. stall[EX_IDX]=1 and stall[MEM_IDX]=0 (bubble): all mem_* outputs ← 0; hilo_tmp_o ← ex_hilo_tmp; cnt_o ← ex_cnt.
  4. stall[EX_IDX]=0 (advance): all mem_* ← matching ex_*; mem_valid ← ex_valid; hilo_tmp_o ← 0; cnt_o ← 0.
  5. otherwise (both stalled): every output holds its value.
- Bubble never writes a register: mem_wreg=0, mem_whilo=0, mem_aluop=NOP.
- stall[EX_IDX]=0 with stall[MEM_IDX]=1 is illegal from the controller; the block treats it as advance (rule 4), and the bench flags it as a protocol error.
- Stall bits other than EX_IDX/MEM_IDX are ignored.
- No arithmetic; values are captured bit-exact, no sign or zero extension.

## Timing
- Latency: exactly 1 cycle from ex_* to mem_* on advance.
- Multi-cycle op: cycle N, execute asserts stall[EX_IDX] with ex_cnt=1 and a partial product. After edge N+1, cnt_o=1 and hilo_tmp_o = partial product, and mem_* is a bubble. Cycle N+1, execute releases stall and presents the final result. After edge N+2, mem_* carries the result and cnt_o=0.
- Stall held k cycles: k consecutive bubbles emitted (if MEM is not stalled). hilo_tmp_o/cnt_o re-capture every bubble cycle.
- Reset or flush mid multi-cycle op: the intermediate state is cleared the same edge. Execute restarts from cnt=0.
- Simultaneous flush and stall: flush wins.

## Structure
- Shared package (existing core definitions): ZeroWord, NOP aluop code, bus widths, stall-vector index constants EX_IDX/MEM_IDX, and RstEnable.
- Single flat module, one clocked process. No sub-module is warranted. The same hold/bubble/advance pattern is reused by the id_ex and mem_wb registers but is not factored out.

## Test plan
- Reset: rst=1 for 2 cycles with all ex_* = 0xFFFFFFFF -> all outputs 0 after the first edge. Released: next edge passes inputs.
- Advance: ex_wd=5, ex_wreg=1, ex_wdata=0x0000_00F0, stall=0 -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0xF0, cnt_o=0.
- Bubble: stall=6'b001111, ex_cnt=1, ex_hilo_tmp=0x1_0000_0002, ex_wreg=1 -> mem_wreg=0, mem_aluop=0, cnt_o=1, hilo_tmp_o=0x1_0000_0002.
- Hold: stall=6'b011111 for 3 cycles after a captured mem_wdata=0xDEADBEEF -> mem_wdata stays 0xDEADBEEF and cnt_o is unchanged all 3 cycles.
- Flush priority: flush=1 with stall=6'b011111 and a live mem_* -> all outputs 0 next edge.
- Multi-cycle sequence: a 2-cycle MADD per the Timing section -> one bubble, then the result with mem_whilo=1 and the correct mem_hi/mem_lo, with cnt_o returning to 0.
